// File: rtl/spsram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spsram_pkg
//  Description : Shared types and constants for the spsram arbiter family.
//  Revision    : 1.0  initial release
// ============================================================================
package spsram_pkg;

    localparam logic PORT_A     = 1'b0;
    localparam logic PORT_B     = 1'b1;
    localparam int   RD_LAT_MAX = 4;

    // One in-flight read: which requester gets the data back.
    typedef struct packed {
        logic valid;
        logic port;
    } rd_tag_t;

endpackage
`default_nettype wire

// File: rtl/spsram_arbiter_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rd_tag_pipe
//  Description : RD_LAT-stage shift register of read tags, cleared on reset.
//  Revision    : 1.0  initial release
// ============================================================================
module rd_tag_pipe
    import spsram_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic    i_clk,
    input  logic    i_rst,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    generate
        if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
            $error("rd_tag_pipe: RD_LAT out of range 1..4");
        end
    endgenerate

    rd_tag_t stage_q [RD_LAT];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= i_tag;
            for (int i = 1; i < RD_LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign o_tag = stage_q[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/spsram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : spsram_arbiter
//  Description : Round-robin sharing of one single-port SRAM by ports A and B,
//                with tagged read-data return.
//  Revision    : 1.0  initial release
// ============================================================================
module spsram_arbiter
    import spsram_pkg::*;
#(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5,
    parameter int RD_LAT  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,

    input  logic               i_a_req,
    input  logic               i_a_we,
    input  logic [BW_ADDR-1:0] i_a_addr,
    input  logic [BW_DATA-1:0] i_a_wdata,
    output logic               o_a_gnt,
    output logic               o_a_rvalid,
    output logic [BW_DATA-1:0] o_a_rdata,

    input  logic               i_b_req,
    input  logic               i_b_we,
    input  logic [BW_ADDR-1:0] i_b_addr,
    input  logic [BW_DATA-1:0] i_b_wdata,
    output logic               o_b_gnt,
    output logic               o_b_rvalid,
    output logic [BW_DATA-1:0] o_b_rdata,

    output logic               o_sram_cen,
    output logic               o_sram_wen,
    output logic               o_sram_oen,
    output logic [BW_ADDR-1:0] o_sram_addr,
    output logic [BW_DATA-1:0] o_sram_wdata,
    input  logic [BW_DATA-1:0] i_sram_rdata
);

    logic               rr_ptr_q, rr_ptr_d;
    logic               w_a_gnt, w_b_gnt;
    logic               w_cen, w_wen;
    logic [BW_ADDR-1:0] w_addr;
    logic [BW_DATA-1:0] w_wdata;
    rd_tag_t            w_tag_in, w_tag_out;
    logic               w_ret_a, w_ret_b;

    logic               a_rvalid_q, b_rvalid_q;
    logic [BW_DATA-1:0] a_rdata_q, b_rdata_q;

    // Grants are suppressed during reset so no command leaks to the SRAM.
    always_comb begin
        w_a_gnt  = ~i_rst & i_a_req & (~i_b_req | (rr_ptr_q == PORT_A));
        w_b_gnt  = ~i_rst & i_b_req & (~i_a_req | (rr_ptr_q == PORT_B));
        rr_ptr_d = rr_ptr_q;
        if (w_a_gnt) begin
            rr_ptr_d = PORT_B;
        end else if (w_b_gnt) begin
            rr_ptr_d = PORT_A;
        end
    end

    always_comb begin
        w_cen   = w_a_gnt | w_b_gnt;
        w_wen   = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (w_a_gnt) begin
            w_wen   = i_a_we;
            w_addr  = i_a_addr;
            w_wdata = i_a_wdata;
        end else if (w_b_gnt) begin
            w_wen   = i_b_we;
            w_addr  = i_b_addr;
            w_wdata = i_b_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_ptr_q <= PORT_A;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        w_tag_in.valid = w_cen & ~w_wen;
        w_tag_in.port  = w_b_gnt ? PORT_B : PORT_A;
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_tag  (w_tag_in),
        .o_tag  (w_tag_out)
    );

    assign w_ret_a = w_tag_out.valid & (w_tag_out.port == PORT_A);
    assign w_ret_b = w_tag_out.valid & (w_tag_out.port == PORT_B);

    // Read data lands one edge after the SRAM presents it; rdata holds otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= w_ret_a;
            b_rvalid_q <= w_ret_b;
            if (w_ret_a) begin
                a_rdata_q <= i_sram_rdata;
            end
            if (w_ret_b) begin
                b_rdata_q <= i_sram_rdata;
            end
        end
    end

    assign o_a_gnt      = w_a_gnt;
    assign o_b_gnt      = w_b_gnt;
    assign o_a_rvalid   = a_rvalid_q;
    assign o_b_rvalid   = b_rvalid_q;
    assign o_a_rdata    = a_rdata_q;
    assign o_b_rdata    = b_rdata_q;
    assign o_sram_cen   = w_cen;
    assign o_sram_wen   = w_wen;
    assign o_sram_oen   = w_tag_out.valid & ~i_rst;
    assign o_sram_addr  = w_addr;
    assign o_sram_wdata = w_wdata;

    // A pending request must keep its payload until it is granted or withdrawn.
    a_payload_stable : assert property (@(posedge i_clk) disable iff (i_rst)
        ($past(i_a_req & ~o_a_gnt) && i_a_req) |->
            ({i_a_we, i_a_addr, i_a_wdata} == $past({i_a_we, i_a_addr, i_a_wdata})));

    b_payload_stable : assert property (@(posedge i_clk) disable iff (i_rst)
        ($past(i_b_req & ~o_b_gnt) && i_b_req) |->
            ({i_b_we, i_b_addr, i_b_wdata} == $past({i_b_we, i_b_addr, i_b_wdata})));

endmodule
`default_nettype wire

// File: tb/tb_spsram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_spsram_arbiter
//  Description : Scoreboard bench driving four arbiters (RD_LAT=1..4) in lockstep.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spsram_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [4:0]  a_addr = 0, b_addr = 0;
    logic [31:0] a_wdata = 0, b_wdata = 0;

    logic [N-1:0] a_gnt, b_gnt, a_rv, b_rv, cen, wen, oen;
    logic [4:0]   s_addr  [N];
    logic [31:0]  s_wdata [N];
    logic [31:0]  s_rdata [N];
    logic [31:0]  a_rdata [N];
    logic [31:0]  b_rdata [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            localparam int LAT = g + 1;
            logic [31:0] mem   [32];
            logic [31:0] rpipe [LAT];

            initial for (int i = 0; i < 32; i++) mem[i] = 32'h0;

            spsram_arbiter #(.BW_DATA(32), .BW_ADDR(5), .RD_LAT(LAT)) u_dut (
                .i_clk(clk), .i_rst(rst),
                .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
                .o_a_gnt(a_gnt[g]), .o_a_rvalid(a_rv[g]), .o_a_rdata(a_rdata[g]),
                .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
                .o_b_gnt(b_gnt[g]), .o_b_rvalid(b_rv[g]), .o_b_rdata(b_rdata[g]),
                .o_sram_cen(cen[g]), .o_sram_wen(wen[g]), .o_sram_oen(oen[g]),
                .o_sram_addr(s_addr[g]), .o_sram_wdata(s_wdata[g]),
                .i_sram_rdata(s_rdata[g])
            );

            // SRAM model: read data appears LAT cycles after the command edge.
            always @(posedge clk) begin
                if (cen[g] && wen[g]) mem[s_addr[g]] <= s_wdata[g];
                rpipe[0] <= (cen[g] && !wen[g]) ? mem[s_addr[g]] : 32'hBAD0_0BAD;
                for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
            end
            assign s_rdata[g] = oen[g] ? rpipe[LAT-1] : 32'hA5A5_A5A5;
        end
    endgenerate

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          gcyc;
    } rd_t;

    logic [31:0] ref_mem [32];
    logic        prio;
    rd_t         rdq [$];
    int          head [N];
    logic [31:0] last_a [N];
    logic [31:0] last_b [N];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic        pa = 0, pa_we = 0, pb = 0, pb_we = 0;
    logic [4:0]  pa_addr = 0, pb_addr = 0;
    logic [31:0] pa_wdata = 0, pb_wdata = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon_port(input int k, input logic p, input logic rv,
                            input logic [31:0] rd, inout logic [31:0] last);
        rd_t e;
        checks++;
        if (rv) begin
            if (head[k] >= rdq.size()) begin
                errors++;
                $display("FAIL unexpected_rvalid lat=%0d port=%0d cyc=%0d data=%h", k+1, p, cyc, rd);
            end else begin
                e = rdq[head[k]];
                head[k]++;
                if (e.port != p || e.data != rd || cyc != e.gcyc + k + 2) begin
                    errors++;
                    $display("FAIL read_return lat=%0d got port=%0d data=%h cyc=%0d want port=%0d data=%h cyc=%0d",
                             k+1, p, rd, cyc, e.port, e.data, e.gcyc + k + 2);
                end
            end
            last = rd;
        end else if (rd != last) begin
            errors++;
            $display("FAIL rdata_hold lat=%0d port=%0d got=%h want=%h", k+1, p, rd, last);
        end
    endtask

    // Monitor: every read return is popped from the scoreboard in grant order.
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            mon_port(k, 1'b0, a_rv[k], a_rdata[k], last_a[k]);
            mon_port(k, 1'b1, b_rv[k], b_rdata[k], last_b[k]);
            while (head[k] < rdq.size() && rdq[head[k]].gcyc + k + 2 < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_rvalid lat=%0d port=%0d due=%0d", k+1, rdq[head[k]].port,
                         rdq[head[k]].gcyc + k + 2);
                head[k]++;
            end
        end
    end

    task automatic apply(input logic p, input logic we, input logic [4:0] ad, input logic [31:0] wd);
        rd_t e;
        if (we) begin
            ref_mem[ad] = wd;
        end else begin
            e.port = p;
            e.data = ref_mem[ad];
            e.gcyc = cyc;
            rdq.push_back(e);
        end
    endtask

    task automatic step(input logic do_rst);
        logic        ega, egb;
        logic [40:0] exp_cmd, act_cmd;
        @(negedge clk);
        #2;
        rst     = do_rst;
        a_req   = pa;  a_we = pa_we;  a_addr = pa_addr;  a_wdata = pa_wdata;
        b_req   = pb;  b_we = pb_we;  b_addr = pb_addr;  b_wdata = pb_wdata;
        #1;
        ega = !do_rst && pa && (!pb || prio == 1'b0);
        egb = !do_rst && pb && (!pa || prio == 1'b1);
        if (ega)      exp_cmd = {1'b1, 1'b0, 1'b1, pa_we, pa_addr, pa_wdata};
        else if (egb) exp_cmd = {1'b0, 1'b1, 1'b1, pb_we, pb_addr, pb_wdata};
        else          exp_cmd = '0;
        for (int k = 0; k < N; k++) begin
            act_cmd = {a_gnt[k], b_gnt[k], cen[k], wen[k], s_addr[k], s_wdata[k]};
            checks++;
            if (act_cmd !== exp_cmd) begin
                errors++;
                $display("FAIL grant_cmd lat=%0d cyc=%0d got=%h want=%h", k+1, cyc, act_cmd, exp_cmd);
            end
        end
        if (ega) begin
            apply(1'b0, pa_we, pa_addr, pa_wdata);
            prio = 1'b1;
            pa   = 1'b0;
        end else if (egb) begin
            apply(1'b1, pb_we, pb_addr, pb_wdata);
            prio = 1'b0;
            pb   = 1'b0;
        end
        if (do_rst) begin
            rdq.delete();
            prio = 1'b0;
            for (int k = 0; k < N; k++) begin
                head[k]   = 0;
                last_a[k] = 32'h0;
                last_b[k] = 32'h0;
            end
        end
    endtask

    task automatic set_a(input logic we, input logic [4:0] ad, input logic [31:0] wd);
        pa = 1'b1; pa_we = we; pa_addr = ad; pa_wdata = wd;
    endtask

    task automatic set_b(input logic we, input logic [4:0] ad, input logic [31:0] wd);
        pb = 1'b1; pb_we = we; pb_addr = ad; pb_wdata = wd;
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((pa || pb) && n < budget) begin
            step(1'b0);
            n++;
        end
        if (pa || pb) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout pa=%0d pb=%0d want=0", pa, pb);
            pa = 1'b0;
            pb = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        wd_flag;
        logic [31:0] v;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        for (int k = 0; k < N; k++) begin
            head[k] = 0; last_a[k] = 0; last_b[k] = 0;
        end
        prio = 1'b0;

        step(1'b1);
        step(1'b1);

        // Write then read back on port A.
        set_a(1'b1, 5'd3, 32'hDEADBEEF);  run_until_idle(4);
        set_a(1'b0, 5'd3, 32'h0);         run_until_idle(4);
        idle(6);

        // Continuous contention: grants must alternate.
        for (int i = 0; i < 6; i++) begin
            if (!pa) set_a(1'b0, 5'($urandom_range(0, 31)), $urandom);
            if (!pb) set_b(1'b0, 5'($urandom_range(0, 31)), $urandom);
            step(1'b0);
        end
        run_until_idle(4);
        idle(6);

        // Make B the priority port, then collide a B write with an A read of the same address.
        set_a(1'b1, 5'd9, 32'h99);        run_until_idle(4);
        set_b(1'b1, 5'd7, 32'h1);
        set_a(1'b0, 5'd7, 32'h0);
        run_until_idle(4);
        idle(6);

        // Back-to-back reads of preloaded addresses.
        for (int i = 0; i < 4; i++) begin
            set_a(1'b1, 5'(i), 32'h10 + i); run_until_idle(4);
        end
        for (int i = 0; i < 4; i++) begin
            set_a(1'b0, 5'(i), 32'h0);      run_until_idle(4);
        end
        idle(6);

        // Reset one cycle after a read grant drops that read; A wins first contention.
        set_a(1'b0, 5'd3, 32'h0);         run_until_idle(4);
        step(1'b1);
        step(1'b1);
        set_a(1'b0, 5'd1, 32'h0);
        set_b(1'b0, 5'd2, 32'h0);
        run_until_idle(4);
        idle(6);

        // Wrap boundary address on both ports.
        set_b(1'b1, 5'd31, 32'hCAFE_F00D); run_until_idle(4);
        set_b(1'b0, 5'd31, 32'h0);         run_until_idle(4);
        set_a(1'b0, 5'd31, 32'h0);         run_until_idle(4);
        set_a(1'b1, 5'd0, 32'h0BAD_CAFE);
        set_b(1'b0, 5'd0, 32'h0);
        run_until_idle(4);
        idle(6);

        // Randomized traffic with withdrawals and occasional resets.
        for (int i = 0; i < 400; i++) begin
            wd_flag = 1'b0;
            if (pa && $urandom_range(0, 9) == 0) begin pa = 1'b0; wd_flag = 1'b1; end
            if (!pa && !wd_flag && $urandom_range(0, 9) < 6) begin
                v = $urandom;
                set_a(v[0], ($urandom_range(0, 3) == 0) ? (v[1] ? 5'd31 : 5'd0) : 5'(v[8:4]), $urandom);
            end
            wd_flag = 1'b0;
            if (pb && $urandom_range(0, 9) == 0) begin pb = 1'b0; wd_flag = 1'b1; end
            if (!pb && !wd_flag && $urandom_range(0, 9) < 6) begin
                v = $urandom;
                set_b(v[0], ($urandom_range(0, 3) == 0) ? (v[1] ? 5'd31 : 5'd0) : 5'(v[8:4]), $urandom);
            end
            step($urandom_range(0, 99) == 0);
        end
        pa = 1'b0;
        pb = 1'b0;
        idle(10);

        for (int k = 0; k < N; k++) begin
            checks++;
            if (head[k] != rdq.size()) begin
                errors++;
                $display("FAIL outstanding_reads lat=%0d got=%0d want=%0d", k+1, head[k], rdq.size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
